// File: rtl/rho_rotate_param.sv
// Multi-cycle Keccak rho lane rotator: one lane at a time, up to STEP bits per cycle.
// Lanes are stored slice-major (bit z of lane i at index 25*z+i) in both ports and the work register.
module rho_rotate_param #(
    parameter int W    = 64,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    input  logic            dir,
    input  logic [5:0]      amt,
    input  logic [25*W-1:0] state_in,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [25*W-1:0] state_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] MASK  = 7'(W - 1);
    localparam logic [6:0] W7    = 7'(W);
    localparam logic [7:0] W8    = 8'(W);
    localparam logic [6:0] STEP7 = 7'(STEP);

    state_t          state_q, state_d;
    logic [25*W-1:0] work_q, work_d;
    logic [25*W-1:0] out_q, out_d;
    logic [4:0]      lane_q, lane_d;
    logic [6:0]      rem_q, rem_d;
    logic            mode_q, mode_d;
    logic            dir_q, dir_d;
    logic [5:0]      amt_q, amt_d;

    logic [W-1:0]    lane_val;
    logic [W-1:0]    rot_val;
    logic [2*W-1:0]  dbl_val;
    logic [2*W-1:0]  shifted;
    logic [6:0]      step_amt;
    logic [6:0]      left_amt;
    logic [7:0]      shr_amt;
    logic            lane_fin;

    // Effective rotation for a lane; W is a power of two so mod W is a mask.
    function automatic logic [6:0] eff_offset(input logic [4:0] idx, input logic m,
                                              input logic [5:0] a);
        logic [6:0] r;
        case (idx)
            5'd0:  r = 7'd0;
            5'd1:  r = 7'd1;
            5'd2:  r = 7'd62;
            5'd3:  r = 7'd28;
            5'd4:  r = 7'd27;
            5'd5:  r = 7'd36;
            5'd6:  r = 7'd44;
            5'd7:  r = 7'd6;
            5'd8:  r = 7'd55;
            5'd9:  r = 7'd20;
            5'd10: r = 7'd3;
            5'd11: r = 7'd10;
            5'd12: r = 7'd43;
            5'd13: r = 7'd25;
            5'd14: r = 7'd39;
            5'd15: r = 7'd41;
            5'd16: r = 7'd45;
            5'd17: r = 7'd15;
            5'd18: r = 7'd21;
            5'd19: r = 7'd8;
            5'd20: r = 7'd18;
            5'd21: r = 7'd2;
            5'd22: r = 7'd61;
            5'd23: r = 7'd56;
            5'd24: r = 7'd14;
            default: r = 7'd0;
        endcase
        if (m) begin
            r = {1'b0, a};
        end
        return r & MASK;
    endfunction

    // Gather the active lane out of the slice-major work register.
    for (genvar gi = 0; gi < W; gi++) begin : g_lane
        assign lane_val[gi] = work_q[25*gi + 32'(lane_q)];
    end

    // Right rotation is folded into a left rotation by (W - s) mod W.
    always_comb begin
        step_amt = (rem_q > STEP7) ? STEP7 : rem_q;
        lane_fin = (rem_q <= STEP7);
        left_amt = dir_q ? ((W7 - step_amt) & MASK) : step_amt;
        dbl_val  = {lane_val, lane_val};
        shr_amt  = W8 - {1'b0, left_amt};
        shifted  = dbl_val >> shr_amt;
        rot_val  = shifted[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        amt_d   = amt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = ROT;
                    work_d  = state_in;
                    lane_d  = 5'd0;
                    rem_d   = eff_offset(5'd0, mode, amt);
                    mode_d  = mode;
                    dir_d   = dir;
                    amt_d   = amt;
                end
            end
            ROT: begin
                for (int z = 0; z < W; z++) begin
                    work_d[25*z + 32'(lane_q)] = rot_val[z];
                end
                rem_d = rem_q - step_amt;
                if (lane_fin) begin
                    if (lane_q == 5'd24) begin
                        state_d = DONE;
                        out_d   = work_d;
                        lane_d  = 5'd0;
                    end else begin
                        lane_d = lane_q + 5'd1;
                        rem_d  = eff_offset(lane_q + 5'd1, mode_q, amt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            out_q   <= '0;
            lane_q  <= 5'd0;
            rem_q   <= 7'd0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            amt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            amt_q   <= amt_d;
        end
    end

    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign busy      = (state_q == ROT);
    assign done      = (state_q == DONE);
    assign state_out = out_q;

endmodule

// File: tb/tb_rho_rotate_param.sv
// Directed bench for rho_rotate_param: three instances (W=64/STEP=64, W=64/STEP=1, W=8/STEP=2).
module tb_rho_rotate_param;

    localparam int RHO [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                                41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    logic           clk = 1'b0;
    logic [2:0]     rst;
    logic [2:0]     start;
    logic [2:0]     ready;
    logic [2:0]     busy;
    logic [2:0]     done;
    logic           mode;
    logic           dir;
    logic [5:0]     amt;
    logic [1599:0]  in64;
    logic [1599:0]  out_f;
    logic [1599:0]  out_s;
    logic [199:0]   in8;
    logic [199:0]   out_8;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    rho_rotate_param #(.W(64), .STEP(64)) u_fast (
        .clk(clk), .reset(rst[0]), .start(start[0]), .mode(mode), .dir(dir), .amt(amt),
        .state_in(in64), .ready(ready[0]), .busy(busy[0]), .done(done[0]), .state_out(out_f)
    );

    rho_rotate_param #(.W(64), .STEP(1)) u_slow (
        .clk(clk), .reset(rst[1]), .start(start[1]), .mode(mode), .dir(dir), .amt(amt),
        .state_in(in64), .ready(ready[1]), .busy(busy[1]), .done(done[1]), .state_out(out_s)
    );

    rho_rotate_param #(.W(8), .STEP(2)) u_w8 (
        .clk(clk), .reset(rst[2]), .start(start[2]), .mode(mode), .dir(dir), .amt(amt),
        .state_in(in8), .ready(ready[2]), .busy(busy[2]), .done(done[2]), .state_out(out_8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane64(input logic [1599:0] v, input int i);
        logic [63:0] r;
        for (int z = 0; z < 64; z++) r[z] = v[25*z + i];
        return r;
    endfunction

    function automatic logic [7:0] lane8(input logic [199:0] v, input int i);
        logic [7:0] r;
        for (int z = 0; z < 8; z++) r[z] = v[25*z + i];
        return r;
    endfunction

    function automatic logic [1599:0] fill64(input logic [63:0] x);
        logic [1599:0] v;
        for (int i = 0; i < 25; i++)
            for (int z = 0; z < 64; z++) v[25*z + i] = x[z];
        return v;
    endfunction

    function automatic logic [199:0] fill8(input logic [7:0] x);
        logic [199:0] v;
        for (int i = 0; i < 25; i++)
            for (int z = 0; z < 8; z++) v[25*z + i] = x[z];
        return v;
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n, input int w);
        logic [63:0] r;
        r = '0;
        for (int z = 0; z < w; z++) r[(z + n) % w] = x[z];
        return r;
    endfunction

    function automatic logic [63:0] cur_l0(input int which);
        case (which)
            0:       return lane64(out_f, 0);
            1:       return lane64(out_s, 0);
            default: return 64'(lane8(out_8, 0));
        endcase
    endfunction

    // Caller raises start[which] before calling; the next edge is the accepting edge.
    task automatic run_op(input int which, input int exp_c, input int pulse_at, input string tag);
        int          cnt;
        bit          seen;
        bit          busy_ok;
        bit          pulsed;
        logic [63:0] pre;
        cnt     = 0;
        seen    = 0;
        busy_ok = 1;
        pulsed  = 0;
        pre     = cur_l0(which);
        @(posedge clk);
        #1;
        start[which] = 1'b0;
        while (!seen && cnt < 2000) begin
            if (done[which]) begin
                seen = 1;
            end else begin
                if (!busy[which] || ready[which] || cur_l0(which) !== pre) busy_ok = 0;
                if (cnt == pulse_at) begin
                    start[which] = 1'b1;
                    in8    = ~in8;
                    in64   = ~in64;
                    pulsed = 1;
                end else if (pulsed) begin
                    start[which] = 1'b0;
                    in8    = ~in8;
                    in64   = ~in64;
                    pulsed = 0;
                end
                @(posedge clk);
                #1;
                cnt++;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_cycles"}, 64'(cnt), 64'(exp_c));
        chk({tag, "_busy_hold"}, 64'(busy_ok), 64'd1);
        chk({tag, "_ready_in_done"}, 64'(ready[which]), 64'd1);
    endtask

    initial begin
        rst   = 3'b111;
        start = 3'b000;
        mode  = 1'b0;
        dir   = 1'b0;
        amt   = 6'd0;
        in64  = '0;
        in8   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready), 64'h7);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_out", 64'(|out_f | |out_s | |out_8), 64'h0);
        rst = 3'b000;

        // Forward rho, full-width steps
        in64     = fill64(64'h1);
        start[0] = 1'b1;
        run_op(0, 25, -1, "t1");
        for (int i = 0; i < 25; i++)
            chk($sformatf("t1_lane%0d", i), lane64(out_f, i), 64'h1 << RHO[i]);
        chk("t1_lane2_const", lane64(out_f, 2), 64'h4000_0000_0000_0000);
        @(posedge clk);
        #1;
        chk("t1_done_one_cycle", 64'(done[0]), 64'h0);
        chk("t1_idle_ready", 64'(ready[0]), 64'h1);

        // Same data one bit per cycle, with a start pulse while busy
        start[1] = 1'b1;
        run_op(1, 681, 300, "t2");
        for (int i = 0; i < 25; i++)
            chk($sformatf("t2_lane%0d", i), lane64(out_s, i), 64'h1 << RHO[i]);

        // Inverse rho undoes the forward result
        in64     = out_f;
        dir      = 1'b1;
        start[0] = 1'b1;
        run_op(0, 25, -1, "t3");
        for (int i = 0; i < 25; i++)
            chk($sformatf("t3_lane%0d", i), lane64(out_f, i), 64'h1);

        // W=8 uniform rotation, amt wraps 11 -> 3; ignored start mid-run
        mode     = 1'b1;
        amt      = 6'd11;
        dir      = 1'b0;
        in8      = fill8(8'h81);
        start[2] = 1'b1;
        run_op(2, 50, 10, "t4a");
        for (int i = 0; i < 25; i++)
            chk($sformatf("t4a_lane%0d", i), 64'(lane8(out_8, i)), 64'h0C);

        // W=8 rho offsets mod 8
        mode     = 1'b0;
        start[2] = 1'b1;
        run_op(2, 53, -1, "t4b");
        chk("t4b_lane2_const", 64'(lane8(out_8, 2)), 64'h60);
        for (int i = 0; i < 25; i++)
            chk($sformatf("t4b_lane%0d", i), 64'(lane8(out_8, i)), rotl(64'h81, RHO[i] % 8, 8));

        // Reset in the middle of a rotation
        start[2] = 1'b1;
        @(posedge clk);
        #1;
        start[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_busy_before_rst", 64'(busy[2]), 64'h1);
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        chk("t5_rst_busy", 64'(busy[2]), 64'h0);
        chk("t5_rst_ready", 64'(ready[2]), 64'h1);
        chk("t5_rst_done", 64'(done[2]), 64'h0);
        chk("t5_rst_out", 64'(|out_8), 64'h0);
        mode     = 1'b1;
        amt      = 6'd11;
        start[2] = 1'b1;
        run_op(2, 50, -1, "t5_after");
        for (int i = 0; i < 25; i++)
            chk($sformatf("t5_lane%0d", i), 64'(lane8(out_8, i)), 64'h0C);

        // Back-to-back: new start accepted in the DONE cycle
        in64     = fill64(64'h1);
        mode     = 1'b0;
        dir      = 1'b0;
        start[0] = 1'b1;
        run_op(0, 25, -1, "t6a");
        chk("t6a_done_high", 64'(done[0]), 64'h1);
        in64     = fill64(64'h1);
        mode     = 1'b1;
        amt      = 6'd4;
        dir      = 1'b1;
        start[0] = 1'b1;
        run_op(0, 25, -1, "t6b");
        for (int i = 0; i < 25; i++)
            chk($sformatf("t6b_lane%0d", i), lane64(out_f, i), 64'h1000_0000_0000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
